// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: 2-bit BHT counter encoding and register constants.
// Used by bht_2bit and hazard_branch_ctrl.
package pipeline_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET_STATE = WNT;
    localparam logic [4:0] REG_X0          = 5'd0;

    // Saturating step of a 2-bit branch counter toward the observed outcome.
    function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = bht_state_e'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = bht_state_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters, indexed by pc[IDX_W+1:2].
// One combinational read port, one clocked update port; a same-index read sees the old value.
module bht_2bit
    import pipeline_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_taken,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int IDX_W = $clog2(ENTRIES);

    bht_state_e      table_q [ENTRIES];
    bht_state_e      rd_state;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic            unused_pc_bits;

    assign rd_idx   = rd_pc[IDX_W+1:2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign rd_state = table_q[rd_idx];
    assign rd_taken = rd_state[1];

    // Only the word-index bits of the PCs select an entry.
    assign unused_pc_bits = ^{rd_pc[XLEN-1:IDX_W+2], rd_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= BHT_RESET_STATE;
            end
        end else if (upd_en) begin
            table_q[upd_idx] <= bht_next(table_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/hazard_branch_ctrl.sv
// Pipeline hazard/branch control: load-use stalls, EX mispredict flush/redirect, BHT prediction.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_branch_ctrl
    import pipeline_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              ex_mem_rd,
    input  logic [4:0]        ex_rd_addr,
    input  logic              ex_branch,
    input  logic              ex_prediction,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_pc,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              redirect,
    output logic              redirect_taken,
    output logic [PERF_W-1:0] perf_mispred,
    output logic [PERF_W-1:0] perf_stall
);

    logic load_use;
    logic mispredict;
    logic stall;

    bht_2bit #(
        .XLEN    (XLEN),
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (if_pc),
        .rd_taken  (pred_taken),
        .upd_en    (ex_branch),
        .upd_pc    (ex_pc),
        .upd_taken (ex_taken)
    );

    assign load_use   = ex_mem_rd && (ex_rd_addr != REG_X0) &&
                        ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));
    assign mispredict = ex_branch && (ex_prediction != ex_taken);

    // A mispredict squashes ID anyway, so stalling it would only hold a wrong-path instruction.
    assign stall = load_use && !mispredict && !rst;

    assign pc_stall       = stall;
    assign if_id_stall    = stall;
    assign if_id_flush    = mispredict && !rst;
    assign id_ex_flush    = (load_use || mispredict) && !rst;
    assign redirect       = mispredict && !rst;
    assign redirect_taken = mispredict && ex_taken && !rst;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] mispred_cnt;
    logic [PERF_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (mispredict) mispred_cnt <= mispred_cnt + 1'b1;
            if (stall)      stall_cnt   <= stall_cnt + 1'b1;
        end
    end

    assign perf_mispred = mispred_cnt;
    assign perf_stall   = stall_cnt;
`else
    assign perf_mispred = '0;
    assign perf_stall   = '0;
`endif

endmodule
